ctrl_pipe: RTL and testbench

//  Pipelined control unit for the 5-stage miniRV core (IF/ID/EX/MEM/WB).

---
 rtl/ctrl_pipe.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control unit for the 5-stage miniRV core. Decodes the ID instruction,
// carries the control bundle through EX/MEM/WB and owns stalls, forwarding and flush.
module ctrl_pipe #(
  parameter bit EXT_EN = 1'b0,
  parameter bit FWD_EN = 1'b1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        mem_stall,
  input  logic        flush_ex,
  output logic [2:0]  id_sext_op,
  output logic        stall_id,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alub_sel,
  output logic [2:0]  ex_br_op,
  output logic [1:0]  ex_npc_op,
  output logic        ex_illegal,
  output logic        mem_valid,
  output logic        mem_ram_we,
  output logic        mem_is_load,
  output logic        wb_valid,
  output logic        wb_rf_we,
  output logic [1:0]  wb_rf_wsel,
  output logic [4:0]  wb_rd
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] BR_NONE   = 3'd7;
  localparam logic [2:0] SEXT_I    = 3'd0;
  localparam logic [2:0] SEXT_S    = 3'd1;
  localparam logic [2:0] SEXT_B    = 3'd2;
  localparam logic [2:0] SEXT_U    = 3'd3;
  localparam logic [2:0] SEXT_J    = 3'd4;
  localparam logic [2:0] SEXT_NONE = 3'd7;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alub_sel;
    logic [2:0] br_op;
    logic [1:0] npc_op;
    logic       ram_we;
    logic       is_load;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic [4:0] rd;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{alu_op: 4'd0, alub_sel: 1'b0, br_op: BR_NONE,
                                  npc_op: 2'd0, ram_we: 1'b0, is_load: 1'b0,
                                  rf_we: 1'b0, rf_wsel: 2'd0, rd: 5'd0, illegal: 1'b0};

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = id_inst[6:0];
  assign funct3 = id_inst[14:12];
  assign funct7 = id_inst[31:25];
  assign rs1    = id_inst[19:15];
  assign rs2    = id_inst[24:20];

  logic       is_imm;
  logic [3:0] alu_dec;
  logic       alu_ok;
  logic [2:0] br_dec;
  logic       br_ok;

  // funct3/funct7 sub-decode shared by the R and I-ALU groups, plus branch kind
  always_comb begin
    is_imm  = (opcode == OP_I);
    alu_dec = ALU_ADD;
    alu_ok  = 1'b0;
    case (funct3)
      3'b000: begin
        alu_dec = (!is_imm && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        alu_ok  = is_imm | (funct7 == F7_BASE) | (funct7 == F7_ALT);
      end
      3'b001: begin alu_dec = ALU_SLL;  alu_ok = (funct7 == F7_BASE); end
      3'b010: begin alu_dec = ALU_SLT;  alu_ok = EXT_EN & (is_imm | (funct7 == F7_BASE)); end
      3'b011: begin alu_dec = ALU_SLTU; alu_ok = EXT_EN & (is_imm | (funct7 == F7_BASE)); end
      3'b100: begin alu_dec = ALU_XOR;  alu_ok = is_imm | (funct7 == F7_BASE); end
      3'b101: begin
        alu_dec = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        alu_ok  = (funct7 == F7_BASE) | (funct7 == F7_ALT);
      end
      3'b110: begin alu_dec = ALU_OR;   alu_ok = is_imm | (funct7 == F7_BASE); end
      default: begin alu_dec = ALU_AND; alu_ok = is_imm | (funct7 == F7_BASE); end
    endcase

    br_dec = BR_NONE;
    br_ok  = 1'b0;
    case (funct3)
      3'b000: begin br_dec = 3'd0; br_ok = 1'b1; end
      3'b001: begin br_dec = 3'd1; br_ok = 1'b1; end
      3'b100: begin br_dec = 3'd2; br_ok = 1'b1; end
      3'b101: begin br_dec = 3'd3; br_ok = 1'b1; end
      3'b110: begin br_dec = 3'd4; br_ok = EXT_EN; end
      3'b111: begin br_dec = 3'd5; br_ok = EXT_EN; end
      default: begin br_dec = BR_NONE; br_ok = 1'b0; end
    endcase
  end

  ctrl_t      dec;
  logic       rs1_rd;
  logic       rs2_rd;
  logic [2:0] sext_dec;

  // Anything not matched stays CTRL_IDLE with illegal=1 and reads no registers
  always_comb begin
    dec         = CTRL_IDLE;
    dec.rd      = id_inst[11:7];
    dec.illegal = 1'b1;
    rs1_rd      = 1'b0;
    rs2_rd      = 1'b0;
    sext_dec    = SEXT_NONE;
    case (opcode)
      OP_R: if (alu_ok) begin
        dec.illegal = 1'b0; dec.alu_op = alu_dec; dec.rf_we = 1'b1;
        rs1_rd = 1'b1; rs2_rd = 1'b1;
      end
      OP_I: if (alu_ok) begin
        dec.illegal = 1'b0; dec.alu_op = alu_dec; dec.alub_sel = 1'b1; dec.rf_we = 1'b1;
        rs1_rd = 1'b1; sext_dec = SEXT_I;
      end
      OP_LOAD: if (funct3 == 3'b010) begin
        dec.illegal = 1'b0; dec.alub_sel = 1'b1; dec.is_load = 1'b1;
        dec.rf_we = 1'b1; dec.rf_wsel = 2'd1;
        rs1_rd = 1'b1; sext_dec = SEXT_I;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        dec.illegal = 1'b0; dec.alub_sel = 1'b1; dec.ram_we = 1'b1;
        rs1_rd = 1'b1; rs2_rd = 1'b1; sext_dec = SEXT_S;
      end
      OP_BRANCH: if (br_ok) begin
        dec.illegal = 1'b0; dec.alu_op = ALU_SUB; dec.br_op = br_dec; dec.npc_op = 2'd2;
        rs1_rd = 1'b1; rs2_rd = 1'b1; sext_dec = SEXT_B;
      end
      OP_LUI: begin
        dec.illegal = 1'b0; dec.rf_we = 1'b1; dec.rf_wsel = 2'd3;
        sext_dec = SEXT_U;
      end
      OP_JAL: begin
        dec.illegal = 1'b0; dec.npc_op = 2'd1; dec.rf_we = 1'b1; dec.rf_wsel = 2'd2;
        sext_dec = SEXT_J;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        dec.illegal = 1'b0; dec.alub_sel = 1'b1; dec.npc_op = 2'd3;
        dec.rf_we = 1'b1; dec.rf_wsel = 2'd2;
        rs1_rd = 1'b1; sext_dec = SEXT_I;
      end
      default: ;
    endcase
  end

  assign id_sext_op = sext_dec;

  ctrl_t      ex_ctrl_reg;
  logic       ex_valid_reg;
  logic       mem_valid_reg;
  logic       mem_ram_we_reg;
  logic       mem_is_load_reg;
  logic       mem_rf_we_reg;
  logic [1:0] mem_rf_wsel_reg;
  logic [4:0] mem_rd_reg;
  logic       wb_valid_reg;
  logic       wb_rf_we_reg;
  logic [1:0] wb_rf_wsel_reg;
  logic [4:0] wb_rd_reg;

  // Stage index 0 = EX (youngest), 1 = MEM, 2 = WB
  logic [2:0] st_valid;
  logic [2:0] st_we;
  logic [4:0] st_rd [3];
  logic [2:0] hit_a;
  logic [2:0] hit_b;

  assign st_valid = {wb_valid_reg, mem_valid_reg, ex_valid_reg};
  assign st_we    = {wb_rf_we_reg, mem_rf_we_reg, ex_ctrl_reg.rf_we};
  assign st_rd[0] = ex_ctrl_reg.rd;
  assign st_rd[1] = mem_rd_reg;
  assign st_rd[2] = wb_rd_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hit
      logic live;
      assign live      = st_valid[gi] & st_we[gi] & (st_rd[gi] != 5'd0);
      assign hit_a[gi] = id_valid & rs1_rd & live & (st_rd[gi] == rs1);
      assign hit_b[gi] = id_valid & rs2_rd & live & (st_rd[gi] == rs2);
    end
  endgenerate

  logic load_use;
  logic hz_stall;
  logic ex_take;

  assign load_use = (hit_a[0] | hit_b[0]) & ex_ctrl_reg.is_load;
  assign hz_stall = FWD_EN ? load_use : ((|hit_a) | (|hit_b));
  assign stall_id = mem_stall | (~flush_ex & hz_stall);
  assign ex_take  = id_valid & ~flush_ex & ~hz_stall;

  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (FWD_EN) begin
      if (hit_a[0] && !ex_ctrl_reg.is_load) fwd_a_sel = 2'd1;
      else if (hit_a[1])                    fwd_a_sel = 2'd2;
      else if (hit_a[2])                    fwd_a_sel = 2'd3;
      if (hit_b[0] && !ex_ctrl_reg.is_load) fwd_b_sel = 2'd1;
      else if (hit_b[1])                    fwd_b_sel = 2'd2;
      else if (hit_b[2])                    fwd_b_sel = 2'd3;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      ex_ctrl_reg     <= CTRL_IDLE;
      ex_valid_reg    <= 1'b0;
      mem_valid_reg   <= 1'b0;
      mem_ram_we_reg  <= 1'b0;
      mem_is_load_reg <= 1'b0;
      mem_rf_we_reg   <= 1'b0;
      mem_rf_wsel_reg <= 2'd0;
      mem_rd_reg      <= 5'd0;
      wb_valid_reg    <= 1'b0;
      wb_rf_we_reg    <= 1'b0;
      wb_rf_wsel_reg  <= 2'd0;
      wb_rd_reg       <= 5'd0;
    end else if (!mem_stall) begin
      ex_valid_reg    <= ex_take;
      ex_ctrl_reg     <= ex_take ? dec : CTRL_IDLE;
      mem_valid_reg   <= ex_valid_reg;
      mem_ram_we_reg  <= ex_valid_reg & ex_ctrl_reg.ram_we;
      mem_is_load_reg <= ex_valid_reg & ex_ctrl_reg.is_load;
      mem_rf_we_reg   <= ex_valid_reg & ex_ctrl_reg.rf_we;
      mem_rf_wsel_reg <= ex_ctrl_reg.rf_wsel;
      mem_rd_reg      <= ex_ctrl_reg.rd;
      wb_valid_reg    <= mem_valid_reg;
      wb_rf_we_reg    <= mem_valid_reg & mem_rf_we_reg;
      wb_rf_wsel_reg  <= mem_rf_wsel_reg;
      wb_rd_reg       <= mem_rd_reg;
    end
  end

  assign ex_valid    = ex_valid_reg;
  assign ex_alu_op   = ex_ctrl_reg.alu_op;
  assign ex_alub_sel = ex_ctrl_reg.alub_sel;
  assign ex_br_op    = ex_valid_reg ? ex_ctrl_reg.br_op : BR_NONE;
  assign ex_npc_op   = ex_valid_reg ? ex_ctrl_reg.npc_op : 2'd0;
  assign ex_illegal  = ex_valid_reg & ex_ctrl_reg.illegal;
  assign mem_valid   = mem_valid_reg;
  assign mem_ram_we  = mem_valid_reg & mem_ram_we_reg;
  assign mem_is_load = mem_valid_reg & mem_is_load_reg;
  assign wb_valid    = wb_valid_reg;
  assign wb_rf_we    = wb_valid_reg & wb_rf_we_reg;
  assign wb_rf_wsel  = wb_rf_wsel_reg;
  assign wb_rd       = wb_rd_reg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: default build plus EXT_EN=1 and FWD_EN=0 variants
// driven from one shared stimulus stream.
module tb_ctrl_pipe;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        mem_stall;
  logic        flush_ex;

  always #5 cpu_clk = ~cpu_clk;

  // default build
  logic [2:0] id_sext_op;  logic stall_id;  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic ex_valid;  logic [3:0] ex_alu_op;  logic ex_alub_sel;  logic [2:0] ex_br_op;
  logic [1:0] ex_npc_op;  logic ex_illegal;  logic mem_valid, mem_ram_we, mem_is_load;
  logic wb_valid, wb_rf_we;  logic [1:0] wb_rf_wsel;  logic [4:0] wb_rd;
  // EXT_EN=1 build
  logic [2:0] x_sext_op;  logic x_stall;  logic [1:0] x_fwd_a, x_fwd_b;
  logic x_ex_valid;  logic [3:0] x_alu_op;  logic x_alub_sel;  logic [2:0] x_br_op;
  logic [1:0] x_npc_op;  logic x_illegal;  logic x_mem_valid, x_ram_we, x_is_load;
  logic x_wb_valid, x_rf_we;  logic [1:0] x_rf_wsel;  logic [4:0] x_rd;
  // FWD_EN=0 build
  logic [2:0] n_sext_op;  logic n_stall;  logic [1:0] n_fwd_a, n_fwd_b;
  logic n_ex_valid;  logic [3:0] n_alu_op;  logic n_alub_sel;  logic [2:0] n_br_op;
  logic [1:0] n_npc_op;  logic n_illegal;  logic n_mem_valid, n_ram_we, n_is_load;
  logic n_wb_valid, n_rf_we;  logic [1:0] n_rf_wsel;  logic [4:0] n_rd;

  ctrl_pipe dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .mem_stall(mem_stall), .flush_ex(flush_ex), .id_sext_op(id_sext_op), .stall_id(stall_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_alub_sel(ex_alub_sel), .ex_br_op(ex_br_op), .ex_npc_op(ex_npc_op),
    .ex_illegal(ex_illegal), .mem_valid(mem_valid), .mem_ram_we(mem_ram_we),
    .mem_is_load(mem_is_load), .wb_valid(wb_valid), .wb_rf_we(wb_rf_we),
    .wb_rf_wsel(wb_rf_wsel), .wb_rd(wb_rd));

  ctrl_pipe #(.EXT_EN(1'b1), .FWD_EN(1'b1)) dut_ext (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .mem_stall(mem_stall), .flush_ex(flush_ex), .id_sext_op(x_sext_op), .stall_id(x_stall),
    .fwd_a_sel(x_fwd_a), .fwd_b_sel(x_fwd_b), .ex_valid(x_ex_valid), .ex_alu_op(x_alu_op),
    .ex_alub_sel(x_alub_sel), .ex_br_op(x_br_op), .ex_npc_op(x_npc_op),
    .ex_illegal(x_illegal), .mem_valid(x_mem_valid), .mem_ram_we(x_ram_we),
    .mem_is_load(x_is_load), .wb_valid(x_wb_valid), .wb_rf_we(x_rf_we),
    .wb_rf_wsel(x_rf_wsel), .wb_rd(x_rd));

  ctrl_pipe #(.EXT_EN(1'b0), .FWD_EN(1'b0)) dut_nf (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .mem_stall(mem_stall), .flush_ex(flush_ex), .id_sext_op(n_sext_op), .stall_id(n_stall),
    .fwd_a_sel(n_fwd_a), .fwd_b_sel(n_fwd_b), .ex_valid(n_ex_valid), .ex_alu_op(n_alu_op),
    .ex_alub_sel(n_alub_sel), .ex_br_op(n_br_op), .ex_npc_op(n_npc_op),
    .ex_illegal(n_illegal), .mem_valid(n_mem_valid), .mem_ram_we(n_ram_we),
    .mem_is_load(n_is_load), .wb_valid(n_wb_valid), .wb_rf_we(n_rf_we),
    .wb_rf_wsel(n_rf_wsel), .wb_rd(n_rd));

  int total = 0;
  int bad   = 0;
  int wr_cnt [32];

  // A register-file write commits on an edge where WB is not frozen
  always @(negedge cpu_clk)
    if (cpu_rst_n && !mem_stall && wb_rf_we) wr_cnt[wb_rd] = wr_cnt[wb_rd] + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #2;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
  endfunction

  initial begin
    cpu_rst_n = 1'b0; id_valid = 1'b0; id_inst = 32'd0; mem_stall = 1'b0; flush_ex = 1'b0;
    repeat (2) @(posedge cpu_clk);
    #2 cpu_rst_n = 1'b1;
    #1;
    // 1: reset state
    check("rst_ex_valid", ex_valid, 0);   check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_valid", wb_valid, 0);   check("rst_ram_we", mem_ram_we, 0);
    check("rst_rf_we", wb_rf_we, 0);      check("rst_br_op", ex_br_op, 7);
    check("rst_npc_op", ex_npc_op, 0);    check("rst_alu_op", ex_alu_op, 0);
    check("rst_wsel", wb_rf_wsel, 0);     check("rst_wb_rd", wb_rd, 0);
    check("rst_stall", stall_id, 0);      check("rst_fwd_a", fwd_a_sel, 0);
    check("rst_fwd_b", fwd_b_sel, 0);     check("rst_sext_none", id_sext_op, 7);

    // 2: forwarding stream
    id_valid = 1'b1; id_inst = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);      // add x3,x1,x2
    #1 check("s_add_stall", stall_id, 0);
    tick(); id_inst = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);               // sub x4,x3,x1
    #1 check("s_sub_fwd_a", fwd_a_sel, 1); check("s_sub_fwd_b", fwd_b_sel, 0);
    check("s_sub_stall", stall_id, 0);     check("s_add_ex_alu", ex_alu_op, 0);
    tick(); id_inst = enc_i(12'd5, 5'd0, 3'b000, 5'd7, 7'b0010011);         // addi x7,x0,5
    #1 check("s_addi_sext", id_sext_op, 0); check("s_sub_ex_alu", ex_alu_op, 1);
    check("s_addi_fwd_a", fwd_a_sel, 0);
    tick(); id_inst = enc_r(7'h00, 5'd3, 5'd4, 3'b110, 5'd9);               // or x9,x4,x3
    #1 check("s_or_fwd_a_mem", fwd_a_sel, 2); check("s_or_fwd_b_wb", fwd_b_sel, 3);
    check("s_addi_alub", ex_alub_sel, 1);     check("s_wb_rd3", wb_rd, 3);
    tick(); id_inst = enc_r(7'h00, 5'd7, 5'd9, 3'b100, 5'd9);               // xor x9,x9,x7
    #1 check("s_xor_fwd_a", fwd_a_sel, 1); check("s_xor_fwd_b", fwd_b_sel, 2);
    tick(); id_inst = enc_r(7'h00, 5'd0, 5'd9, 3'b111, 5'd11);              // and x11,x9,x0
    #1 check("s_and_ex_over_mem", fwd_a_sel, 1); check("s_and_fwd_b_x0", fwd_b_sel, 0);
    tick(); id_inst = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd0);               // add x0,x1,x1
    tick(); id_inst = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd12);              // add x12,x0,x0
    #1 check("s_x0_fwd_a", fwd_a_sel, 0); check("s_x0_fwd_b", fwd_b_sel, 0);

    // 3: load-use
    tick(); id_inst = enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011);         // lw x5,0(x0)
    #1 check("lu_lw_stall", stall_id, 0);
    tick(); id_inst = enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd6);               // add x6,x5,x5
    #1 check("lu_stall", stall_id, 1); check("lu_ex_valid", ex_valid, 1);
    tick();
    #1 check("lu_stall_once", stall_id, 0); check("lu_bubble", ex_valid, 0);
    check("lu_bubble_br", ex_br_op, 7);      check("lu_mem_load", mem_is_load, 1);
    check("lu_fwd_a", fwd_a_sel, 2);         check("lu_fwd_b", fwd_b_sel, 2);

    // 4: flush while the ID instruction is in load-use with EX
    tick(); id_inst = enc_i(12'd0, 5'd0, 3'b010, 5'd13, 7'b0000011);        // lw x13,0(x0)
    #1 check("lu_wb_wsel", wb_rf_wsel, 1); check("lu_wb_rd", wb_rd, 5);
    tick(); id_inst = enc_r(7'h00, 5'd0, 5'd13, 3'b000, 5'd14); flush_ex = 1'b1;
    #1 check("fl_stall", stall_id, 0);
    tick(); flush_ex = 1'b0; id_valid = 1'b0;
    #1 check("fl_bubble", ex_valid, 0); check("lu_use_wb_rd", wb_rd, 6);
    tick(); tick();
    #1 check("fl_wb_empty", wb_valid, 0);
    check("fl_killed_no_write", wr_cnt[14], 0); check("lu_single_write", wr_cnt[6], 1);

    // 5: mem_stall for three edges mid-stream
    id_valid = 1'b1; id_inst = enc_i(12'd1, 5'd0, 3'b000, 5'd15, 7'b0010011);
    tick(); id_inst = enc_i(12'd2, 5'd0, 3'b000, 5'd16, 7'b0010011);
    tick(); id_inst = enc_i(12'd3, 5'd0, 3'b000, 5'd17, 7'b0010011);
    tick(); id_inst = enc_r(7'h00, 5'd16, 5'd17, 3'b000, 5'd18); mem_stall = 1'b1;
    #1 check("ms_stall", stall_id, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) mem_stall = 1'b0;
      #1 check("ms_hold_wb_rd", wb_rd, 15); check("ms_hold_ex", ex_valid, 1);
      check("ms_fwd_a", fwd_a_sel, 1);       check("ms_fwd_b", fwd_b_sel, 2);
      check("ms_stall_id", stall_id, (i == 2) ? 0 : 1);
    end
    tick(); id_valid = 1'b0;
    #1 check("ms_resume_wb_rd", wb_rd, 16);
    tick(); tick(); tick();
    #1 for (int r = 15; r <= 18; r++) check("ms_one_write", wr_cnt[r], 1);

    // 6: decode, default and EXT_EN=1 builds
    id_valid = 1'b1; id_inst = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd19);     // sltu x19
    #1 check("d_sltu_sext", id_sext_op, 7);
    tick(); id_inst = enc_b(5'd2, 5'd1, 3'b111);                             // bgeu
    #1 check("d_bgeu_sext_ext", x_sext_op, 2);
    check("d_sltu_illegal", ex_illegal, 1); check("d_sltu_ill_br", ex_br_op, 7);
    check("d_sltu_ext_alu", x_alu_op, 9);   check("d_sltu_ext_legal", x_illegal, 0);
    tick(); id_inst = enc_b(5'd0, 5'd0, 3'b000);                             // beq
    #1 check("d_beq_sext", id_sext_op, 2); check("d_bgeu_illegal", ex_illegal, 1);
    check("d_bgeu_ext_br", x_br_op, 5);    check("d_bgeu_ext_npc", x_npc_op, 2);
    tick(); id_inst = {7'd0, 5'd1, 5'd0, 3'b010, 5'd0, 7'b0100011};          // sw x1,0(x0)
    #1 check("d_sw_sext", id_sext_op, 1); check("d_beq_br", ex_br_op, 0);
    check("d_beq_npc", ex_npc_op, 2);     check("d_sltu_wb_valid", wb_valid, 1);
    check("d_sltu_no_we", wb_rf_we, 0);
    tick(); id_inst = {20'd0, 5'd20, 7'b1101111};                            // jal x20
    #1 check("d_jal_sext", id_sext_op, 4); check("d_sw_alub", ex_alub_sel, 1);
    tick(); id_inst = {20'h12345, 5'd21, 7'b0110111};                        // lui x21
    #1 check("d_lui_sext", id_sext_op, 3); check("d_sw_ram_we", mem_ram_we, 1);
    check("d_jal_npc", ex_npc_op, 1);
    tick(); id_valid = 1'b0;
    tick();
    #1 check("d_jal_wsel", wb_rf_wsel, 2); check("d_jal_rd", wb_rd, 20);
    tick();
    #1 check("d_lui_wsel", wb_rf_wsel, 3); check("d_sltu_never_wrote", wr_cnt[19], 0);

    // asynchronous reset with the pipe full
    id_valid = 1'b1; id_inst = enc_i(12'd1, 5'd0, 3'b000, 5'd22, 7'b0010011);
    tick(); id_inst = enc_i(12'd1, 5'd0, 3'b000, 5'd23, 7'b0010011);
    tick(); cpu_rst_n = 1'b0;
    #1 check("ar_ex_valid", ex_valid, 0); check("ar_mem_valid", mem_valid, 0);
    check("ar_wb_valid", wb_valid, 0);
    id_valid = 1'b0;
    tick(); cpu_rst_n = 1'b1;

    // FWD_EN=0: dependent add stalls for three cycles
    id_valid = 1'b1; id_inst = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);      // add x3,x1,x2
    #1 check("nf_first_stall", n_stall, 0);
    tick(); id_inst = enc_r(7'h00, 5'd3, 5'd3, 3'b000, 5'd4);               // add x4,x3,x3
    #1 check("nf_fwd_a_zero", n_fwd_a, 0); check("nf_fwd_b_zero", n_fwd_b, 0);
    check("fw_no_stall", stall_id, 0);     check("fw_fwd_a", fwd_a_sel, 1);
    for (int i = 0; i < 3; i++) begin
      #1 check("nf_stall", n_stall, 1);
      tick();
    end
    #1 check("nf_released", n_stall, 0); check("nf_bubble", n_ex_valid, 0);
    tick(); id_valid = 1'b0;
    #1 check("nf_issued", n_ex_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
